// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the parametrised pipeline stage register:
// stall-vector polarity, a zero payload word and the stage-register states.
package pipe_stage_reg_pkg;

    // Stall vector polarity: 1 holds the stage, 0 lets it run.
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [63:0] ZeroWord = 64'h0;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID2 = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_stage_perf.sv
// Saturating performance counters for a pipeline stage register.
// Built only when PIPE_STAGE_PERF_EN is defined. Cleared by reset only.
module pipe_stage_perf
    import pipe_stage_reg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        bubble_inc,
    input  logic        bp_inc,
    output logic [31:0] bubble_cnt,
    output logic [31:0] bp_cnt
);

    logic [31:0] r_bubble_cnt;
    logic [31:0] r_bp_cnt;

    // Count bubbles and back-pressure cycles, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bubble_cnt <= 32'h0;
            r_bp_cnt     <= 32'h0;
        end else begin
            if (bubble_inc && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
            if (bp_inc && (r_bp_cnt != 32'hFFFF_FFFF)) begin
                r_bp_cnt <= r_bp_cnt + 32'd1;
            end
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign bp_cnt     = r_bp_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, global
// stall-vector gating, optional two-entry skid buffer, flush and zeroed bubbles.
// Optional feature macro: PIPE_STAGE_PERF_EN adds bubble_cnt / bp_cnt outputs.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned STAGE   = 4,
    parameter int unsigned STALL_W = 6,
    parameter int unsigned SKID    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [STALL_W-1:0] stall,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [1:0]         occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]        bubble_cnt,
    output logic [31:0]        bp_cnt
`endif
);

    if (STAGE + 1 >= STALL_W) begin : g_bad_cfg
        $error("pipe_stage_reg: STAGE+1 must be below STALL_W");
    end

    state_e              r_state;
    state_e              w_state_d;
    logic [DATA_W-1:0]   r_main;
    logic [DATA_W-1:0]   w_main_d;
    logic [DATA_W-1:0]   w_skid_q;
    logic [DATA_W-1:0]   w_skid_d;
    logic                w_in_fire;
    logic                w_out_fire;

    assign out_valid  = (r_state != ST_EMPTY);
    // Main is zeroed whenever it empties, so bubbles carry an all-zero payload.
    assign out_data   = r_main;
    assign occupancy  = r_state;
    assign w_in_fire  = in_valid & in_ready & (stall[STAGE] == NoStop);
    assign w_out_fire = out_valid & out_ready & (stall[STAGE+1] == NoStop);

    // Next-state and data movement; skid entry always leaves after main.
    always_comb begin
        w_state_d = r_state;
        w_main_d  = r_main;
        w_skid_d  = w_skid_q;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_d = ST_FULL;
                    w_main_d  = in_data;
                end
            end
            ST_FULL: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_d = in_data;
                end else if (w_in_fire) begin
                    w_state_d = ST_SKID2;
                    w_skid_d  = in_data;
                end else if (w_out_fire) begin
                    w_state_d = ST_EMPTY;
                    w_main_d  = '0;
                end
            end
            ST_SKID2: begin
                if (w_out_fire) begin
                    w_state_d = ST_FULL;
                    w_main_d  = w_skid_q;
                    w_skid_d  = '0;
                end
            end
            default: begin
                w_state_d = ST_EMPTY;
                w_main_d  = '0;
                w_skid_d  = '0;
            end
        endcase
    end

    // State and main entry; reset outranks flush, both drop any same-cycle input.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
        end else begin
            r_state <= w_state_d;
            r_main  <= w_main_d;
        end
    end

    if (SKID != 0) begin : g_skid
        logic [DATA_W-1:0] r_skid;
        logic              r_in_ready;

        // Skid entry and registered ready, which never sees out_ready or stall directly.
        always_ff @(posedge clk) begin
            if (reset || flush) begin
                r_skid     <= '0;
                r_in_ready <= 1'b1;
            end else begin
                r_skid     <= w_skid_d;
                r_in_ready <= (w_state_d != ST_SKID2);
            end
        end

        assign w_skid_q = r_skid;
        assign in_ready = r_in_ready;
    end else begin : g_no_skid
        // Single entry: accept only when the held payload leaves this cycle.
        assign w_skid_q = '0;
        assign in_ready = ~out_valid | (out_ready & (stall[STAGE+1] == NoStop));
    end

`ifdef PIPE_STAGE_PERF_EN
    logic w_bubble_inc;
    logic w_bp_inc;

    assign w_bubble_inc = ~out_valid;
    assign w_bp_inc     = in_valid & ~in_ready;

    pipe_stage_perf u_perf (
        .clk        (clk),
        .reset      (reset),
        .bubble_inc (w_bubble_inc),
        .bp_inc     (w_bp_inc),
        .bubble_cnt (bubble_cnt),
        .bp_cnt     (bp_cnt)
    );
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register: the next generation of the fixed-field inter-stage registers (if/id, id/ex, ex/mem, mem/wb).
- Carries an opaque DATA_W-bit payload; each stage packs and unpacks its own fields.
- Keeps the global stall-vector protocol (Stop/NoStop per stage) and adds a valid/ready handshake, an optional 2-entry skid buffer, an exception flush and zeroed bubbles.
- Sits between any two adjacent pipeline stages and replaces the per-stage hand-written registers.

Parameters:
DATA_W, 64, payload width in bits (>=1).
STAGE, 4, index of the upstream stage in the stall vector; the downstream stage is STAGE+1.
STALL_W, 6, width of the stall vector; elaboration error unless STAGE+1 < STALL_W.
SKID, 1, 1 = two-entry skid with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high.
flush  in  1  exception/ERET flush; discards all held entries.
stall  in  STALL_W  global stall vector, 1 = Stop.
in_valid  in  1  upstream payload valid.
in_ready  out  1  stage can accept a payload.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  downstream payload valid.
out_ready  in  1  downstream can accept.
out_data  out  DATA_W  payload; all-zero whenever out_valid=0.
occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Clock and reset: reset is synchronous and active-high; the clock is clk.
- Fire conditions:
  - in_fire = in_valid & in_ready & ~stall[STAGE]
  - out_fire = out_valid & out_ready & ~stall[STAGE+1]
- Upstream stalled with downstream running produces a bubble: out_valid=0, out_data=0. This matches the legacy zero-insert rule.
- Priority: reset > flush > normal operation.
- Reset or flush, next cycle: state=EMPTY, main and skid registers = 0, out_valid=0, occupancy=0, in_ready=1. Any in_fire in the same cycle is dropped. Reset or flush mid-transfer discards both entries.
- States (SKID=1), with main driving out_data:
  - EMPTY:
    - in_fire -> FULL, main <= in_data.
    - otherwise stay.
  - FULL:
    - in_fire & out_fire -> FULL, main <= in_data.
    - in_fire & ~out_fire -> SKID2, skid <= in_data.
    - ~in_fire & out_fire -> EMPTY, main <= 0.
    - otherwise hold.
  - SKID2:
    - out_fire -> FULL, main <= skid, skid <= 0.
    - otherwise hold; no in_fire is possible.
- in_ready (SKID=1): registered; equals (next state != SKID2). It is never combinationally dependent on out_ready or stall.
- SKID=0:
  - in_ready = ~out_valid | (out_ready & ~stall[STAGE+1]), combinational.
  - SKID2 is unreachable; the skid register is not built.
- Latency: one cycle from in_fire to out_valid. Throughput is one payload per cycle when downstream accepts every cycle.
- Ordering: strict FIFO, so the skid entry always exits after main. No payload is ever duplicated or dropped except by flush/reset.
- Held data stays stable while out_valid=1 and ~out_fire.
- occupancy: EMPTY=0, FULL=1, SKID2=2.

Optional Feature:
PIPE_STAGE_PERF_EN
- Defined: adds output ports bubble_cnt[31:0] and bp_cnt[31:0]. Both are saturating at 32'hFFFFFFFF, cleared by reset only (not by flush).
  - bubble_cnt increments each cycle with out_valid=0.
  - bp_cnt increments each cycle with in_valid & ~in_ready.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package/header (global_define): Stop=1'b1, NoStop=1'b0, ZeroWord, state encodings ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID2=2'd2.
- One sub-module: pipe_stage_perf, holding the two saturating counters; instantiated only under PIPE_STAGE_PERF_EN.

Test Plan:
1. Reset, then stream 0x11, 0x22, 0x33 with out_ready=1 and stall=0 -> out_data shows 0x11, 0x22, 0x33 on consecutive cycles, each one cycle after input; occupancy=1 throughout.
2. SKID=1: accept 0xA0 and 0xA1 with out_ready=0 -> occupancy=2 and in_ready=0 the next cycle; raise out_ready -> 0xA0 then 0xA1, in_ready returns to 1.
3. stall[4]=1, stall[5]=0 with in_valid=1, data 0x55, one entry held -> held entry drains, then out_valid=0 and out_data=0 (bubble); 0x55 is not accepted until stall[4]=0.
4. stall[5]=1 with 0x77 held -> 0x77 and out_valid held stable for all stalled cycles; no out_fire.
5. Occupancy=2 (0xB0, 0xB1), assert flush for one cycle with in_valid=1 and data 0xB2 -> next cycle occupancy=0, out_data=0, in_ready=1; 0xB2 never appears at the output.
6. PIPE_STAGE_PERF_EN: 10 cycles idle after reset -> bubble_cnt=10; 3 cycles of in_valid=1 with in_ready=0 -> bp_cnt=3; flush leaves both counts unchanged.
